// File: rtl/ringosc_freq_meter_if.sv
// Control/result bundle between the IO wrapper and the ring-oscillator frequency meter.
interface ringosc_freq_meter_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   start;
  logic [2:0]             window_sel;
  logic                   src_sel;
  logic [2:0]             tap_sel;
  logic                   busy;
  logic                   done;
  logic [COUNT_WIDTH-1:0] count;
  logic                   overflow;

  modport master (
    output start, window_sel, src_sel, tap_sel,
    input  busy, done, count, overflow
  );

  modport slave (
    input  start, window_sel, src_sel, tap_sel,
    output busy, done, count, overflow
  );
endinterface

// File: rtl/ringosc_freq_meter.sv
// Gated inverter ring with selectable taps, plus a windowed edge counter that
// measures either a ring tap or ext_clk and hands the result back into clk.
module ringosc_freq_meter #(
  parameter int CHAIN_LENGTH = 1000,
  parameter int COUNT_WIDTH  = 16,
  parameter int DIV_LOG2     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ring_en,
  input  logic                 ext_clk,
  ringosc_freq_meter_if.slave  ctrl,
  output logic                 tap_div_out
);

  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, CAPTURE} state_e;

  state_e                 state_q, state_d;
  logic [11:0]            cyc_q, cyc_d;
  logic                   src_sel_q, src_sel_d;
  logic [2:0]             tap_sel_q, tap_sel_d;
  logic [2:0]             window_sel_q, window_sel_d;
  logic                   clr_q, clr_d;
  logic                   gate_q, gate_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [11:0]            win_len_m1;

  logic [CHAIN_LENGTH-1:0] inv_chain;
  logic                    nand_out;
  logic [7:0]              tap;
  logic                    meas_clk;
  logic                    meas_rst_n;

  logic                   gate_s1_q, gate_s2_q;
  logic [COUNT_WIDTH-1:0] meas_cnt_q, meas_cnt_d;
  logic                   meas_ovf_q, meas_ovf_d;

  logic [DIV_LOG2:0]      div_clk;

  // The NAND stage closes the loop; with ring_en low its output is pinned high
  // and the even-length inverter chain settles to a static pattern.
  assign nand_out     = ~(ring_en & inv_chain[CHAIN_LENGTH-1]);
  assign inv_chain[0] = ~nand_out;

  for (genvar i = 1; i < CHAIN_LENGTH; i++) begin : g_inv
    assign inv_chain[i] = ~inv_chain[i-1];
  end

  for (genvar t = 0; t < 8; t++) begin : g_tap
    assign tap[t] = inv_chain[t*CHAIN_LENGTH/8];
  end

  // Source selects are only changed at an accepted start, so any mux glitch
  // lands inside CLEAR while the counter is held in reset.
  assign meas_clk   = src_sel_q ? ext_clk : tap[tap_sel_q];
  assign meas_rst_n = rst_n & ~clr_q;
  assign win_len_m1 = (12'd16 << window_sel_q) - 12'd1;

  assign ctrl.busy     = (state_q != IDLE);
  assign ctrl.done     = done_q;
  assign ctrl.count    = count_q;
  assign ctrl.overflow = ovf_q;

  // Control FSM registers, latched selects and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      src_sel_q    <= 1'b0;
      tap_sel_q    <= '0;
      window_sel_q <= '0;
      clr_q        <= 1'b0;
      gate_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      src_sel_q    <= src_sel_d;
      tap_sel_q    <= tap_sel_d;
      window_sel_q <= window_sel_d;
      clr_q        <= clr_d;
      gate_q       <= gate_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      count_q      <= count_d;
    end
  end

  // Sequencing: one down-counter times CLEAR (4), GATE (W) and SETTLE (4).
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    src_sel_d    = src_sel_q;
    tap_sel_d    = tap_sel_q;
    window_sel_d = window_sel_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl.start) begin
          src_sel_d    = ctrl.src_sel;
          tap_sel_d    = ctrl.tap_sel;
          window_sel_d = ctrl.window_sel;
          cyc_d        = 12'd3;
          state_d      = CLEAR;
        end
      end
      CLEAR: begin
        if (cyc_q == 12'd0) begin
          cyc_d   = win_len_m1;
          state_d = GATE;
        end else begin
          cyc_d = cyc_q - 12'd1;
        end
      end
      GATE: begin
        if (cyc_q == 12'd0) begin
          cyc_d   = 12'd3;
          state_d = SETTLE;
        end else begin
          cyc_d = cyc_q - 12'd1;
        end
      end
      SETTLE: begin
        if (cyc_q == 12'd0) begin
          state_d = CAPTURE;
        end else begin
          cyc_d = cyc_q - 12'd1;
        end
      end
      CAPTURE: begin
        count_d = meas_ovf_q ? {COUNT_WIDTH{1'b1}} : meas_cnt_q;
        ovf_d   = meas_ovf_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    clr_d  = (state_d == CLEAR);
    gate_d = (state_d == GATE);
  end

  // Gate crossing into the measured domain; cleared with the counter so a
  // stalled source cannot leave a stale gate behind.
  always_ff @(posedge meas_clk or negedge meas_rst_n) begin
    if (!meas_rst_n) begin
      gate_s1_q <= 1'b0;
      gate_s2_q <= 1'b0;
    end else begin
      gate_s1_q <= gate_q;
      gate_s2_q <= gate_s1_q;
    end
  end

  // Edge counter with sticky wrap flag; keeps counting after a wrap.
  always_comb begin
    meas_cnt_d = meas_cnt_q + {{(COUNT_WIDTH-1){1'b0}}, gate_s2_q};
    meas_ovf_d = meas_ovf_q | (gate_s2_q & (&meas_cnt_q));
  end

  // Counter registers, cleared asynchronously so CLEAR works on a dead clock.
  always_ff @(posedge meas_clk or negedge meas_rst_n) begin
    if (!meas_rst_n) begin
      meas_cnt_q <= '0;
      meas_ovf_q <= 1'b0;
    end else begin
      meas_cnt_q <= meas_cnt_d;
      meas_ovf_q <= meas_ovf_d;
    end
  end

  assign div_clk[0] = meas_clk;

  for (genvar d = 0; d < DIV_LOG2; d++) begin : g_div
    logic stage_q, stage_d;

    // Each stage toggles on the falling edge of the previous stage output.
    always_comb begin
      stage_d = ~stage_q;
    end

    // Ripple divider flop, free-running on the selected source.
    always_ff @(posedge div_clk[d] or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= 1'b0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign div_clk[d+1] = ~stage_q;
  end

  assign tap_div_out = ~div_clk[DIV_LOG2];

endmodule

// File: doc/ringosc_freq_meter.md
Name: ringosc_freq_meter

Overview:
- Next-generation ring-oscillator block: a parametrised, gated inverter ring with selectable taps and an on-chip frequency counter.
- A clk-domain FSM opens a counting window of programmable length. Edges of the selected source (ring tap or external pin) are counted in their own domain, then captured safely into clk.
- Sits directly behind the chip-level IO wrapper. Result is read out over pins by the wrapper.
- Ring stages are the existing inverter cell; the gating stage is a standard NAND2 cell.

Parameters:
- CHAIN_LENGTH, 1000: number of inverter cells in the ring. Must be even; the NAND enable stage makes the total inversion count odd.
- COUNT_WIDTH, 16: width of the count result.
- DIV_LOG2, 10: divider exponent for tap_div_out. Output = selected source / 2^DIV_LOG2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ring_en  in  1  1 = ring oscillates; 0 = ring static
- src_sel  in  1  0 = ring tap, 1 = ext_clk
- tap_sel  in  3  ring tap select; tap n = output of inverter n*CHAIN_LENGTH/8
- ext_clk  in  1  external reference, asynchronous to clk
- start  in  1  request a measurement (level, sampled in IDLE)
- window_sel  in  3  window length W = 16 << window_sel clk cycles (16..2048)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when count is updated
- count  out  COUNT_WIDTH  last measured edge count
- overflow  out  1  last measurement exceeded 2^COUNT_WIDTH-1
- tap_div_out  out  1  selected source divided by 2^DIV_LOG2, for pin observation

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: busy=0, done=0, count=0, overflow=0, tap_div_out=0, FSM=IDLE. Measurement-domain counter, sync flops and divider are all cleared.
- Ring structure: NAND(ring_en, last inverter out) drives inverter 0, closing the loop. ring_en=0 forces the NAND output high, so the chain settles static.
- Measured source: meas_clk = src_sel_q ? ext_clk : tap[tap_sel_q].
  - src_sel_q and tap_sel_q are registered in clk when start is accepted, and held until the next accepted start.
  - Mux glitches at a switch fall only within CLEAR and are discarded.
- FSM (clk domain): IDLE -> CLEAR(4) -> GATE(W) -> SETTLE(4) -> CAPTURE(1) -> IDLE. Numbers are clk cycles in each state.
  - IDLE: start=1 at an edge is accepted. Latch src_sel, tap_sel, window_sel; go to CLEAR. busy=1 from the next cycle.
  - CLEAR: registered clr=1. The meas counter and overflow bit are asynchronously reset by (~rst_n | clr). Works even when meas_clk is stopped.
  - GATE: registered gate=1 for exactly W cycles, via a window counter of 12 bits.
  - SETTLE: gate=0. Allows the 2-flop gate synchroniser and the counter to go quiet.
  - CAPTURE: count <= overflow ? all-ones : meas_cnt; overflow <= meas_ovf; done=1 for this cycle only; busy=0 from the next cycle.
- Start latency: start accepted at edge k gives done high in the cycle following edge k+W+9.
- Measurement domain (clocked on meas_clk rising edge):
  - gate passes through a 2-flop synchroniser.
  - meas_cnt increments while the synchronised gate=1.
  - On wrap from all-ones, meas_ovf is set (sticky) and meas_cnt keeps wrapping.
- Expected count: roughly f_meas * W / f_clk, ±2 edges of synchroniser uncertainty.
- Stopped source: if meas_clk is stopped, the result is 0 with overflow=0. No lockup.
- start handling: start while busy is ignored. Held start re-triggers immediately after return to IDLE; back-to-back measurements are W+10 cycles apart.
- Input changes mid-measurement:
  - ring_en, src_sel or tap_sel changes affect only the next measurement's latched values.
  - ring_en is not latched; dropping it during GATE yields a partial count, with no error flag.
- Reset mid-operation: asynchronous return to IDLE with all outputs at reset values. A previous count is lost.
- tap_div_out: ripple divider on meas_clk, toggling independently of the FSM, asynchronously reset by rst_n only.

Test Plan:
- Reset: assert rst_n=0 mid-GATE -> busy=0, done=0, count=0, overflow=0 immediately; FSM back in IDLE.
- External source, nominal: clk 50 MHz, ext_clk 12.5 MHz, src_sel=1, window_sel=4 (W=256), 1-cycle start -> done exactly 265 cycles after the accept edge; count=64±2; overflow=0.
- Overflow with COUNT_WIDTH=8: ext_clk=clk/2, window_sel=7 (W=2048) -> overflow=1, count=8'hFF. Next run with window_sel=0 (W=16) -> overflow=0, count=8±2.
- Stopped source: ext_clk held 0, src_sel=1, after a previous count of 64 -> count=0, done pulses, no hang.
- Start held high: start held for 3 measurements at W=16 -> three done pulses exactly 26 cycles apart; start pulses during busy produce no extra done.
- Ring path (gate-level sim with cell delays): ring_en=1, tap_sel=0..7 each -> nonzero count, identical ±2 across taps; ring_en=0 -> count=0; tap_div_out toggles only while ring_en=1.
